// File: rtl/ag32gbd_pkg.sv
// Shared definitions for the AG32 Game Boy cartridge-bus host: FSM encoding,
// default SRAM chip-select window and the window decode helper.
package ag32gbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [15:0] CS_LO_DEFAULT = 16'hA000;
  localparam logic [15:0] CS_HI_DEFAULT = 16'hFDFF;

  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

  function automatic logic is_bus_phase(input state_t s);
    return (s == ST_P0) || (s == ST_P1) || (s == ST_P2) || (s == ST_P3);
  endfunction

endpackage

// File: rtl/ag32gbd_phase_timer.sv
// Quarter-phase down-counter: start loads T_PHASE-1, reloads itself after every
// terminal count while active, clear stops it; last_tick flags the final cycle of a phase.
module ag32gbd_phase_timer #(
  parameter int T_PHASE = 12
) (
  input  logic sys_clock,
  input  logic resetn,
  input  logic start,
  input  logic clear,
  output logic last_tick
);

  localparam int CW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
  localparam logic [CW-1:0] LOAD = CW'(T_PHASE - 1);

  logic [CW-1:0] count;
  logic          active;

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      count  <= '0;
      active <= 1'b0;
    end else if (clear) begin
      count  <= '0;
      active <= 1'b0;
    end else if (start || (active && (count == '0))) begin
      count  <= LOAD;
      active <= 1'b1;
    end else if (active) begin
      count  <= count - CW'(1);
    end
  end

  assign last_tick = active && (count == '0);

endmodule

// File: rtl/ag32gbd_cart_host.sv
// Game Boy cartridge-bus initiator: one command -> one four-phase bus cycle.
// Optional macro CART_HOST_CLK_OUT_EN enables the phi-style Cart_CLK pulse.
module ag32gbd_cart_host
  import ag32gbd_pkg::*;
#(
  parameter int          T_PHASE = 12,
  parameter logic [15:0] CS_LO   = CS_LO_DEFAULT,
  parameter logic [15:0] CS_HI   = CS_HI_DEFAULT
) (
  input  logic        sys_clock,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] Cart_a,
  output logic [7:0]  Cart_d_out,
  output logic        Cart_d_oe,
  input  logic [7:0]  Cart_d_in,
  output logic        Cart_nRD,
  output logic        Cart_nWR,
  output logic        Cart_nCS,
  output logic        Cart_CLK
);

  state_t      state, state_next;
  logic        ready_en;
  logic        accept;
  logic        last_tick;
  logic        busy_next;

  logic        wr_reg;
  logic        hit_reg;
  logic [7:0]  wdata_reg;
  logic [15:0] addr_reg;
  logic [7:0]  rdata_reg;

  logic        wr_eff, hit_eff;
  logic [7:0]  wdata_eff;

  logic        ncs_next, nrd_next, nwr_next, oe_next;
  logic [7:0]  dout_next;
  logic        ncs_reg, nrd_reg, nwr_reg, oe_reg;
  logic [7:0]  dout_reg;

  assign cmd_ready = ready_en && (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state == ST_DONE);
  assign rsp_rdata = rdata_reg;
  assign Cart_a    = addr_reg;

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept)    state_next = ST_P0;
      ST_P0:   if (last_tick) state_next = ST_P1;
      ST_P1:   if (last_tick) state_next = ST_P2;
      ST_P2:   if (last_tick) state_next = ST_P3;
      ST_P3:   if (last_tick) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy_next = is_bus_phase(state_next);

  ag32gbd_phase_timer #(
    .T_PHASE (T_PHASE)
  ) u_timer (
    .sys_clock (sys_clock),
    .resetn    (resetn),
    .start     (accept),
    .clear     (!busy_next),
    .last_tick (last_tick)
  );

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      wr_reg    <= 1'b0;
      hit_reg   <= 1'b0;
      wdata_reg <= '0;
      addr_reg  <= '0;
    end else if (accept) begin
      wr_reg    <= cmd_write;
      hit_reg   <= in_window(cmd_addr, CS_LO, CS_HI);
      wdata_reg <= cmd_wdata;
      addr_reg  <= cmd_addr;
    end
  end

  // Writes report zero so a stale read byte is never mistaken for fresh data.
  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      rdata_reg <= '0;
    end else if ((state == ST_P3) && last_tick) begin
      rdata_reg <= wr_reg ? 8'h00 : Cart_d_in;
    end
  end

  // Pins are decoded from the next state and registered, so they line up with
  // the FSM and stay glitch-free on the cartridge connector.
  assign wr_eff    = accept ? cmd_write : wr_reg;
  assign hit_eff   = accept ? in_window(cmd_addr, CS_LO, CS_HI) : hit_reg;
  assign wdata_eff = accept ? cmd_wdata : wdata_reg;

  always_comb begin
    ncs_next  = 1'b1;
    nrd_next  = 1'b1;
    nwr_next  = 1'b1;
    oe_next   = 1'b0;
    dout_next = 8'h00;
    if (busy_next) begin
      ncs_next = !hit_eff;
    end
    if ((state_next == ST_P1) || (state_next == ST_P2) || (state_next == ST_P3)) begin
      if (wr_eff) begin
        oe_next   = 1'b1;
        dout_next = wdata_eff;
      end else begin
        nrd_next  = 1'b0;
      end
    end
    if ((state_next == ST_P2) && wr_eff) begin
      nwr_next = 1'b0;
    end
  end

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      ncs_reg  <= 1'b1;
      nrd_reg  <= 1'b1;
      nwr_reg  <= 1'b1;
      oe_reg   <= 1'b0;
      dout_reg <= '0;
    end else begin
      ncs_reg  <= ncs_next;
      nrd_reg  <= nrd_next;
      nwr_reg  <= nwr_next;
      oe_reg   <= oe_next;
      dout_reg <= dout_next;
    end
  end

  assign Cart_nCS   = ncs_reg;
  assign Cart_nRD   = nrd_reg;
  assign Cart_nWR   = nwr_reg;
  assign Cart_d_oe  = oe_reg;
  assign Cart_d_out = dout_reg;

`ifdef CART_HOST_CLK_OUT_EN
  // One high pulse per bus cycle covering the first half (P0, P1).
  logic clk_reg;

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      clk_reg <= 1'b0;
    end else begin
      clk_reg <= (state_next == ST_P0) || (state_next == ST_P1);
    end
  end

  assign Cart_CLK = clk_reg;
`else
  assign Cart_CLK = 1'b0;
`endif

endmodule

// File: tb/tb_ag32gbd_cart_host.sv
// Self-checking bench for ag32gbd_cart_host: cycle-offset reference model checked
// every negedge, plus directed transactions with literal expectations.
module tb_ag32gbd_cart_host;

  localparam int T   = 4;
  localparam int BUS = 4 * T;

  logic        sys_clock = 1'b0;
  logic        resetn    = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr  = 16'h0000;
  logic [7:0]  cmd_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] Cart_a;
  logic [7:0]  Cart_d_out;
  logic        Cart_d_oe;
  logic [7:0]  Cart_d_in = 8'h00;
  logic        Cart_nRD;
  logic        Cart_nWR;
  logic        Cart_nCS;
  logic        Cart_CLK;

  ag32gbd_cart_host #(
    .T_PHASE (T)
  ) dut (
    .sys_clock  (sys_clock),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .Cart_a     (Cart_a),
    .Cart_d_out (Cart_d_out),
    .Cart_d_oe  (Cart_d_oe),
    .Cart_d_in  (Cart_d_in),
    .Cart_nRD   (Cart_nRD),
    .Cart_nWR   (Cart_nWR),
    .Cart_nCS   (Cart_nCS),
    .Cart_CLK   (Cart_CLK)
  );

  always #5 sys_clock = ~sys_clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Reference model: position inside a bus cycle is the cycle offset k since accept.
  bit          m_active = 1'b0;
  int          m_k = 0;
  bit          m_wr, m_hit, m_ready_en = 1'b0;
  logic [15:0] m_a = 16'h0000;
  logic [7:0]  m_wdata, m_rdata = 8'h00, m_din;
  bit          e_ready, in_bus, data_ph, done, e_clk;

  int cyc = 0;
  int acc_cyc = 0, acc_prev = 0, n_acc = 0, n_rsp = 0;
  int c_nrd = 0, c_nwr = 0, c_oe = 0, c_ncs = 0;
  int last_nrd = 0, last_nwr = 0, last_oe = 0, last_ncs = 0, last_lat = 0;
  logic [7:0] last_rdata = 8'h00;

  always @(posedge sys_clock) cyc++;

  always @(negedge sys_clock) begin
    if (!resetn) begin
      chk("rst_ready", 32'(cmd_ready), 32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_rdata", 32'(rsp_rdata), 32'(0));
      chk("rst_a", 32'(Cart_a), 32'(0));
      chk("rst_dout", 32'(Cart_d_out), 32'(0));
      chk("rst_oe", 32'(Cart_d_oe), 32'(0));
      chk("rst_nrd", 32'(Cart_nRD), 32'(1));
      chk("rst_nwr", 32'(Cart_nWR), 32'(1));
      chk("rst_ncs", 32'(Cart_nCS), 32'(1));
      chk("rst_clk", 32'(Cart_CLK), 32'(0));
      m_active   = 1'b0;
      m_ready_en = 1'b0;
      m_rdata    = 8'h00;
      m_a        = 16'h0000;
    end else begin
      e_ready = m_ready_en && !m_active;
      in_bus  = m_active && (m_k >= 1) && (m_k <= BUS);
      data_ph = m_active && (m_k > T) && (m_k <= BUS);
      done    = m_active && (m_k == BUS + 1);
      if (done) m_rdata = m_wr ? 8'h00 : m_din;
`ifdef CART_HOST_CLK_OUT_EN
      e_clk = m_active && (m_k >= 1) && (m_k <= 2 * T);
`else
      e_clk = 1'b0;
`endif
      chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(done));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
      chk("cart_a", 32'(Cart_a), 32'(m_a));
      chk("ncs", 32'(Cart_nCS), 32'(!(in_bus && m_hit)));
      chk("nrd", 32'(Cart_nRD), 32'(!(data_ph && !m_wr)));
      chk("oe", 32'(Cart_d_oe), 32'(data_ph && m_wr));
      chk("dout", 32'(Cart_d_out), 32'((data_ph && m_wr) ? m_wdata : 8'h00));
      chk("nwr", 32'(Cart_nWR), 32'(!(m_active && m_wr && (m_k > 2 * T) && (m_k <= 3 * T))));
      chk("cart_clk", 32'(Cart_CLK), 32'(e_clk));

      if (cmd_valid && cmd_ready) begin
        acc_prev = acc_cyc;
        acc_cyc  = cyc;
        n_acc++;
        c_nrd = 0; c_nwr = 0; c_oe = 0; c_ncs = 0;
      end else begin
        c_nrd += int'(!Cart_nRD);
        c_nwr += int'(!Cart_nWR);
        c_oe  += int'(Cart_d_oe);
        c_ncs += int'(!Cart_nCS);
      end
      if (rsp_valid) begin
        n_rsp++;
        last_nrd = c_nrd; last_nwr = c_nwr; last_oe = c_oe; last_ncs = c_ncs;
        last_lat = cyc - acc_cyc;
        last_rdata = rsp_rdata;
      end

      if (m_active && (m_k == BUS)) m_din = Cart_d_in;
      if (m_active) begin
        m_k++;
        if (m_k > BUS + 1) m_active = 1'b0;
      end
      if (e_ready && cmd_valid) begin
        m_active = 1'b1;
        m_k      = 1;
        m_wr     = cmd_write;
        m_hit    = (cmd_addr >= 16'hA000) && (cmd_addr <= 16'hFDFF);
        m_a      = cmd_addr;
        m_wdata  = cmd_wdata;
      end
      m_ready_en = 1'b1;
    end
  end

  task automatic run_cmd(input logic wr, input logic [15:0] a,
                         input logic [7:0] wd, input logic [7:0] din);
    int n;
    cmd_write = wr; cmd_addr = a; cmd_wdata = wd; Cart_d_in = din; cmd_valid = 1'b1;
    n = 0;
    @(negedge sys_clock);
    while (!cmd_ready && n < 50) begin @(negedge sys_clock); n++; end
    if (!cmd_ready) timeout_fail("accept_wait");
    @(posedge sys_clock); #1;
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~a; cmd_wdata = ~wd;
    n = 0;
    @(negedge sys_clock);
    while (!rsp_valid && n < 100) begin @(negedge sys_clock); n++; end
    if (!rsp_valid) timeout_fail("rsp_wait");
    @(posedge sys_clock); #1;
  endtask

  logic [15:0] bnd_addr [4] = '{16'h9FFF, 16'hA000, 16'hFDFF, 16'hFE00};
  int          bnd_ncs  [4] = '{0, 16, 16, 0};
  int          r0, a0, cnt, n;

  initial begin
    repeat (3) @(posedge sys_clock);
    #1;
    chk("lit_reset_ready", 32'(cmd_ready), 32'(0));
    chk("lit_reset_nrd", 32'(Cart_nRD), 32'(1));
    chk("lit_reset_ncs", 32'(Cart_nCS), 32'(1));
    resetn = 1'b1;
    @(posedge sys_clock); #1;
    chk("lit_ready_after_release", 32'(cmd_ready), 32'(1));

    run_cmd(1'b0, 16'h0150, 8'h00, 8'h3C);
    chk("lit_rd_latency", 32'(last_lat), 32'(17));
    chk("lit_rd_nrd_cycles", 32'(last_nrd), 32'(12));
    chk("lit_rd_ncs_cycles", 32'(last_ncs), 32'(0));
    chk("lit_rd_oe_cycles", 32'(last_oe), 32'(0));
    chk("lit_rd_rdata", 32'(last_rdata), 32'(8'h3C));

    run_cmd(1'b1, 16'hA005, 8'h55, 8'hEE);
    chk("lit_wr_latency", 32'(last_lat), 32'(17));
    chk("lit_wr_ncs_cycles", 32'(last_ncs), 32'(16));
    chk("lit_wr_oe_cycles", 32'(last_oe), 32'(12));
    chk("lit_wr_nwr_cycles", 32'(last_nwr), 32'(4));
    chk("lit_wr_nrd_cycles", 32'(last_nrd), 32'(0));
    chk("lit_wr_rdata", 32'(last_rdata), 32'(0));

    for (int i = 0; i < 4; i++) begin
      run_cmd(1'b0, bnd_addr[i], 8'h00, 8'(8'h10 + i));
      chk("lit_cs_boundary_ncs", 32'(last_ncs), 32'(bnd_ncs[i]));
      chk("lit_cs_boundary_rdata", 32'(last_rdata), 32'(8'h10 + i));
    end

    // cmd_valid held across two bus cycles: exactly two accepts, second 18 cycles later.
    a0 = n_acc;
    cmd_write = 1'b0; cmd_addr = 16'h4000; Cart_d_in = 8'hA5; cmd_valid = 1'b1;
    cnt = 0; n = 0;
    while (cnt < 2 && n < 100) begin
      @(negedge sys_clock);
      if (cmd_ready) cnt++;
      n++;
    end
    if (cnt < 2) timeout_fail("b2b_accepts");
    @(posedge sys_clock); #1;
    cmd_valid = 1'b0;
    n = 0;
    @(negedge sys_clock);
    while (!rsp_valid && n < 100) begin @(negedge sys_clock); n++; end
    if (!rsp_valid) timeout_fail("b2b_rsp");
    @(posedge sys_clock); #1;
    chk("lit_b2b_gap", 32'(acc_cyc - acc_prev), 32'(18));
    chk("lit_b2b_accepts", 32'(n_acc - a0), 32'(2));
    chk("lit_b2b_rdata", 32'(last_rdata), 32'(8'hA5));

    // Abort a write in P2 with reset.
    cmd_write = 1'b1; cmd_addr = 16'hA123; cmd_wdata = 8'h77; cmd_valid = 1'b1;
    n = 0;
    @(negedge sys_clock);
    while (!cmd_ready && n < 50) begin @(negedge sys_clock); n++; end
    if (!cmd_ready) timeout_fail("abort_accept");
    @(posedge sys_clock); #1;
    cmd_valid = 1'b0;
    repeat (9) @(posedge sys_clock);
    #1;
    chk("lit_abort_nwr_before", 32'(Cart_nWR), 32'(0));
    chk("lit_abort_oe_before", 32'(Cart_d_oe), 32'(1));
    r0 = n_rsp;
    resetn = 1'b0;
    #1;
    chk("lit_abort_nwr_after", 32'(Cart_nWR), 32'(1));
    chk("lit_abort_oe_after", 32'(Cart_d_oe), 32'(0));
    chk("lit_abort_ncs_after", 32'(Cart_nCS), 32'(1));
    repeat (2) @(posedge sys_clock);
    #1;
    resetn = 1'b1;
    repeat (20) @(posedge sys_clock);
    #1;
    chk("lit_abort_no_rsp", 32'(n_rsp), 32'(r0));

    run_cmd(1'b0, 16'hC000, 8'h00, 8'h81);
    chk("lit_post_abort_latency", 32'(last_lat), 32'(17));
    chk("lit_post_abort_ncs", 32'(last_ncs), 32'(16));
    chk("lit_post_abort_rdata", 32'(last_rdata), 32'(8'h81));

    repeat (3) @(posedge sys_clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
